// File: rtl/fetch_unit_if.sv
// Instruction-bus bundle between the fetch front end and instruction memory.
// Request is held (valid and address stable) until the single data_ok strobe returns.
interface fetch_unit_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues hold-until-data_ok bus requests,
// buffers an instruction across stalls and discards fetches made stale by a redirect.
module fetch_unit #(
  parameter logic [63:0] PC_INIT = 64'h8000_0000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_unit_if.master      ibus,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              all_ready,
  input  logic              stall,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [63:0]       fetch_pc,
  output logic [31:0]       fetch_insn,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

  state_t      state, state_nxt;
  logic [63:0] pc, pc_nxt;
  logic [31:0] buf_insn, buf_insn_nxt;
  logic [63:0] pend_pc, pend_pc_nxt;
  logic        adv;

  assign adv       = all_ready & ~stall;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= PC_INIT;
      buf_insn <= '0;
      pend_pc  <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      buf_insn <= buf_insn_nxt;
      pend_pc  <= pend_pc_nxt;
    end
  end

  // fetch_ready never looks at all_ready, which keeps the global ready AND loop-free.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    buf_insn_nxt    = buf_insn;
    pend_pc_nxt     = pend_pc;
    ibus.ireq_valid = 1'b0;
    ibus.ireq_addr  = '0;
    fetch_valid     = 1'b0;
    fetch_ready     = 1'b1;
    fetch_pc        = pc;
    fetch_insn      = '0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        ibus.ireq_valid = 1'b1;
        ibus.ireq_addr  = pc;
        fetch_valid     = ibus.iresp_data_ok & ~redirect_valid;
        fetch_insn      = ibus.iresp_data;
        fetch_ready     = ibus.iresp_data_ok | redirect_valid;
        if (redirect_valid && ibus.iresp_data_ok) begin
          pc_nxt = redirect_pc;
        end else if (redirect_valid) begin
          pend_pc_nxt = redirect_pc;
          state_nxt   = DISCARD;
        end else if (ibus.iresp_data_ok && adv) begin
          pc_nxt = pc + 64'd4;
        end else if (ibus.iresp_data_ok) begin
          buf_insn_nxt = ibus.iresp_data;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        fetch_valid = ~redirect_valid;
        fetch_insn  = buf_insn;
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = REQ;
        end else if (adv) begin
          pc_nxt    = pc + 64'd4;
          state_nxt = REQ;
        end
      end
      DISCARD: begin
        // The stale request stays on the bus untouched until its response drains.
        ibus.ireq_valid = 1'b1;
        ibus.ireq_addr  = pc;
        if (redirect_valid) pend_pc_nxt = redirect_pc;
        if (ibus.iresp_data_ok) begin
          pc_nxt    = redirect_valid ? redirect_pc : pend_pc;
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: default-PC instance for the main sequence,
// a second instance with PC_INIT near the top of the address space for wraparound.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset_a, reset_b;
  logic        rv_a, rv_b, ar_a, ar_b, st_a, st_b;
  logic [63:0] rpc_a, rpc_b;
  logic        fr_a, fv_a, fr_b, fv_b;
  logic [63:0] fpc_a, fpc_b;
  logic [31:0] fi_a, fi_b;
  logic [1:0]  ds_a, ds_b;
  int          checks = 0;
  int          errors = 0;

  fetch_unit_if bus_a();
  fetch_unit_if bus_b();

  always #5 clk = ~clk;

  fetch_unit dut_a (
    .clk(clk), .reset(reset_a), .ibus(bus_a),
    .redirect_valid(rv_a), .redirect_pc(rpc_a), .all_ready(ar_a), .stall(st_a),
    .fetch_ready(fr_a), .fetch_valid(fv_a), .fetch_pc(fpc_a), .fetch_insn(fi_a),
    .dbg_state(ds_a)
  );

  fetch_unit #(.PC_INIT(64'hFFFF_FFFF_FFFF_FFFC)) dut_b (
    .clk(clk), .reset(reset_b), .ibus(bus_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b), .all_ready(ar_b), .stall(st_b),
    .fetch_ready(fr_b), .fetch_valid(fv_b), .fetch_pc(fpc_b), .fetch_insn(fi_b),
    .dbg_state(ds_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_a = 1'b0; reset_b = 1'b0;
    rv_a = 1'b0; rpc_a = '0; ar_a = 1'b1; st_a = 1'b0;
    rv_b = 1'b0; rpc_b = '0; ar_b = 1'b1; st_b = 1'b0;
    bus_a.iresp_data_ok = 1'b0; bus_a.iresp_data = '0;
    bus_b.iresp_data_ok = 1'b0; bus_b.iresp_data = '0;

    // Reset state
    tick(); settle();
    chk("rst_ireq_valid", bus_a.ireq_valid, 0);
    chk("rst_ireq_addr", bus_a.ireq_addr, 0);
    chk("rst_fetch_valid", fv_a, 0);
    chk("rst_fetch_ready", fr_a, 1);
    chk("rst_fetch_pc", fpc_a, 64'h8000_0000);
    chk("rst_fetch_insn", fi_a, 0);
    chk("rst_state", ds_a, 0);

    @(negedge clk); reset_a = 1'b1;
    // First edge after release leaves IDLE; zero-wait bus from here.
    tick();
    bus_a.iresp_data_ok = 1'b1; bus_a.iresp_data = 32'h1111_0001; settle();
    chk("s0_ireq_valid", bus_a.ireq_valid, 1);
    chk("s0_addr", bus_a.ireq_addr, 64'h8000_0000);
    chk("s0_fetch_valid", fv_a, 1);
    chk("s0_fetch_insn", fi_a, 32'h1111_0001);
    tick();
    bus_a.iresp_data = 32'h1111_0002; settle();
    chk("s1_addr", bus_a.ireq_addr, 64'h8000_0004);
    chk("s1_fetch_valid", fv_a, 1);
    chk("s1_fetch_pc", fpc_a, 64'h8000_0004);
    tick();
    bus_a.iresp_data = 32'h0000_0013; st_a = 1'b1; settle();
    chk("s2_addr", bus_a.ireq_addr, 64'h8000_0008);
    chk("s2_fetch_valid", fv_a, 1);
    chk("s2_fetch_insn", fi_a, 32'h13);

    // Stalled: instruction held and re-presented, no bus request
    for (int i = 0; i < 3; i++) begin
      tick();
      bus_a.iresp_data_ok = 1'b0; bus_a.iresp_data = 32'hDEAD_BEEF; settle();
      chk("hold_ireq_valid", bus_a.ireq_valid, 0);
      chk("hold_fetch_insn", fi_a, 32'h13);
      chk("hold_fetch_pc", fpc_a, 64'h8000_0008);
      chk("hold_fetch_valid", fv_a, 1);
    end
    st_a = 1'b0; settle();
    chk("hold_release_valid", fv_a, 1);
    tick(); settle();
    chk("after_hold_ireq_valid", bus_a.ireq_valid, 1);
    chk("after_hold_addr", bus_a.ireq_addr, 64'h8000_000C);
    bus_a.iresp_data_ok = 1'b1; settle();
    tick();
    bus_a.iresp_data_ok = 1'b0; settle();
    chk("req10_addr", bus_a.ireq_addr, 64'h8000_0010);

    // Redirect one cycle into an unanswered fetch
    tick();
    rv_a = 1'b1; rpc_a = 64'h8000_1000; settle();
    chk("redir_fetch_valid", fv_a, 0);
    chk("redir_fetch_ready", fr_a, 1);
    chk("redir_addr", bus_a.ireq_addr, 64'h8000_0010);
    tick();
    rv_a = 1'b0; settle();
    chk("disc_ireq_valid", bus_a.ireq_valid, 1);
    chk("disc_addr", bus_a.ireq_addr, 64'h8000_0010);
    chk("disc_state", ds_a, 3);
    tick();
    bus_a.iresp_data_ok = 1'b1; bus_a.iresp_data = 32'h5555_5555; settle();
    chk("stale_fetch_valid", fv_a, 0);
    chk("stale_addr", bus_a.ireq_addr, 64'h8000_0010);
    tick();
    bus_a.iresp_data_ok = 1'b0; settle();
    chk("newpc_addr", bus_a.ireq_addr, 64'h8000_1000);

    // Two redirects while discarding: the later one wins
    rv_a = 1'b1; rpc_a = 64'h100; settle();
    tick();
    rpc_a = 64'h200; settle();
    chk("disc2_addr", bus_a.ireq_addr, 64'h8000_1000);
    tick();
    rv_a = 1'b0; bus_a.iresp_data_ok = 1'b1; settle();
    chk("disc2_fetch_valid", fv_a, 0);
    tick();
    bus_a.iresp_data_ok = 1'b0; settle();
    chk("two_redir_addr", bus_a.ireq_addr, 64'h200);

    // Redirect coinciding with data_ok
    bus_a.iresp_data_ok = 1'b1; rv_a = 1'b1; rpc_a = 64'h300; settle();
    chk("coinc_fetch_valid", fv_a, 0);
    chk("coinc_fetch_ready", fr_a, 1);
    tick();
    bus_a.iresp_data_ok = 1'b0; rv_a = 1'b0; settle();
    chk("coinc_ireq_valid", bus_a.ireq_valid, 1);
    chk("coinc_addr", bus_a.ireq_addr, 64'h300);
    chk("req_nodata_ready", fr_a, 0);

    // Enter HOLD, then assert reset asynchronously
    bus_a.iresp_data_ok = 1'b1; bus_a.iresp_data = 32'h0000_0ABC; st_a = 1'b1; settle();
    tick();
    bus_a.iresp_data_ok = 1'b0; settle();
    chk("hold2_ireq_valid", bus_a.ireq_valid, 0);
    chk("hold2_insn", fi_a, 32'hABC);
    chk("hold2_pc", fpc_a, 64'h300);
    #2 reset_a = 1'b0; settle();
    chk("arst_ireq_valid", bus_a.ireq_valid, 0);
    chk("arst_fetch_valid", fv_a, 0);
    chk("arst_fetch_pc", fpc_a, 64'h8000_0000);
    chk("arst_fetch_ready", fr_a, 1);
    chk("arst_state", ds_a, 0);

    // PC wraparound on the second instance
    @(negedge clk); reset_b = 1'b1;
    tick();
    bus_b.iresp_data_ok = 1'b1; bus_b.iresp_data = 32'h13; settle();
    chk("wrap_first_addr", bus_b.ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_fetch_valid", fv_b, 1);
    tick();
    bus_b.iresp_data_ok = 1'b0; settle();
    chk("wrap_next_addr", bus_b.ireq_addr, 64'h0);
    chk("wrap_ireq_valid", bus_b.ireq_valid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
